// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: combinational mfc0 reads with WB bypass, WB-stage mtc0 commits,
// Count/Compare timer, exception/ERET state and interrupt-pending generation.
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  read_addr,
  input  logic [2:0]  read_sel,
  output logic [31:0] read_data,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [2:0]  write_sel,
  input  logic [31:0] write_data,
  input  logic [5:0]  int_in,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay_slot,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        int_pending,
  output logic        timer_int
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;
  localparam logic [4:0]  ADDR_PRID     = 5'd15;
  localparam logic [31:0] STATUS_MASK   = 32'h1040_FF03;  // CU0, BEV, IM, EXL, IE

  logic [31:0] badvaddr_q, count_q, compare_q, status_q, epc_q;
  logic        count_toggle_q;
  logic        cause_bd_q, cause_ti_q;
  logic [4:0]  cause_exc_code_q;
  logic [1:0]  cause_ip_sw_q;
  logic [5:0]  int_q;
  logic [31:0] cause_value, reg_value, write_value;

  // An exception commit swallows any mtc0 in the same cycle; ERET only swallows a Status write.
  logic write_ok, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign write_ok   = write_en && (write_sel == 3'd0) && !exc_valid;
  assign wr_count   = write_ok && (write_addr == ADDR_COUNT);
  assign wr_compare = write_ok && (write_addr == ADDR_COMPARE);
  assign wr_status  = write_ok && (write_addr == ADDR_STATUS) && !eret;
  assign wr_cause   = write_ok && (write_addr == ADDR_CAUSE);
  assign wr_epc     = write_ok && (write_addr == ADDR_EPC);

  // IP7 folds the timer in combinationally so clearing TI drops the request at once.
  assign cause_value = {cause_bd_q, cause_ti_q, 14'd0, int_q[5] | cause_ti_q, int_q[4:0],
                        cause_ip_sw_q, 1'b0, cause_exc_code_q, 2'b00};

  assign status      = status_q;
  assign cause       = cause_value;
  assign epc         = epc_q;
  assign timer_int   = cause_ti_q;
  assign int_pending = status_q[0] && !status_q[1] && |(status_q[15:8] & cause_value[15:8]);

  // NOTE: every variable assigned in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    reg_value = 32'd0;
    if (read_sel == 3'd0) begin
      case (read_addr)
        ADDR_BADVADDR: reg_value = badvaddr_q;
        ADDR_COUNT:    reg_value = count_q;
        ADDR_COMPARE:  reg_value = compare_q;
        ADDR_STATUS:   reg_value = status_q;
        ADDR_CAUSE:    reg_value = cause_value;
        ADDR_EPC:      reg_value = epc_q;
        ADDR_PRID:     reg_value = PRID_VALUE;
        default:       reg_value = 32'd0;
      endcase
    end
  end

  // Post-write image of the register being written; read-only and unimplemented ones keep reg_value.
  always_comb begin
    write_value = reg_value;
    case (write_addr)
      ADDR_COUNT, ADDR_COMPARE, ADDR_EPC: write_value = write_data;
      ADDR_STATUS: write_value = write_data & STATUS_MASK;
      ADDR_CAUSE:  write_value = {cause_value[31:10], write_data[9:8], cause_value[7:0]};
      default:     write_value = reg_value;
    endcase
  end

  always_comb begin
    read_data = reg_value;
    if (write_en && !exc_valid && (write_sel == 3'd0) && (read_sel == 3'd0) &&
        (write_addr == read_addr))
      read_data = write_value;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q        <= 32'd0;
      count_toggle_q <= 1'b0;
      compare_q      <= 32'd0;
      cause_ti_q     <= 1'b0;
    end else begin
      if (wr_count) begin
        count_q        <= write_data;
        count_toggle_q <= 1'b0;
      end else begin
        count_toggle_q <= !count_toggle_q;
        if (count_toggle_q) count_q <= count_q + 32'd1;
      end
      if (wr_compare) begin
        compare_q  <= write_data;
        cause_ti_q <= 1'b0;
      end else if ((count_q == compare_q) && !wr_count) begin
        cause_ti_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= STATUS_RESET;
    end else if (exc_valid) begin
      status_q[1] <= 1'b1;
    end else if (eret) begin
      status_q[1] <= 1'b0;
    end else if (wr_status) begin
      status_q <= write_data & STATUS_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q            <= 32'd0;
      badvaddr_q       <= 32'd0;
      cause_bd_q       <= 1'b0;
      cause_exc_code_q <= 5'd0;
      cause_ip_sw_q    <= 2'b00;
      int_q            <= 6'd0;
    end else begin
      int_q <= int_in;
      if (exc_valid) begin
        // A nested exception (EXL already set) must not overwrite the original return point.
        if (!status_q[1]) begin
          epc_q      <= exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
          cause_bd_q <= exc_in_delay_slot;
        end
        cause_exc_code_q <= exc_code;
        if ((exc_code == 5'd4) || (exc_code == 5'd5)) badvaddr_q <= exc_badvaddr;
      end else begin
        if (wr_epc)   epc_q         <= write_data;
        if (wr_cause) cause_ip_sw_q <= write_data[9:8];
      end
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile: reset, timer, exceptions, priority, bypass, wrap.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_addr;
  logic [2:0]  read_sel;
  logic [31:0] read_data;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [2:0]  write_sel;
  logic [31:0] write_data;
  logic [5:0]  int_in;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] status, cause, epc;
  logic        int_pending, timer_int;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk(clk), .rst(rst),
    .read_addr(read_addr), .read_sel(read_sel), .read_data(read_data),
    .write_en(write_en), .write_addr(write_addr), .write_sel(write_sel), .write_data(write_data),
    .int_in(int_in), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_in_delay_slot(exc_in_delay_slot), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .status(status), .cause(cause), .epc(epc), .int_pending(int_pending), .timer_int(timer_int)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mfc0(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
    read_addr = a;
    read_sel  = s;
    #1;
    d = read_data;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    write_en   = 1'b1;
    write_addr = a;
    write_sel  = 3'd0;
    write_data = d;
    step();
    write_en = 1'b0;
  endtask

  task automatic raise(input logic [31:0] pc, input logic ds, input logic [4:0] code,
                       input logic [31:0] bad);
    exc_valid         = 1'b1;
    exc_pc            = pc;
    exc_in_delay_slot = ds;
    exc_code          = code;
    exc_badvaddr      = bad;
    step();
    exc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    read_addr = 5'd0; read_sel = 3'd0;
    write_en = 1'b0; write_addr = 5'd0; write_sel = 3'd0; write_data = 32'd0;
    int_in = 6'd0; exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0;
    exc_in_delay_slot = 1'b0; exc_badvaddr = 32'd0; eret = 1'b0;

    // Reset state
    #3;
    check("reset_status", status, 32'h0040_0000);
    check("reset_cause", cause, 32'h0);
    check("reset_epc", epc, 32'h0);
    check("reset_int_pending", {31'd0, int_pending}, 32'd0);
    check("reset_timer_int", {31'd0, timer_int}, 32'd0);
    mfc0(5'd15, 3'd0, rd);
    check("prid", rd, 32'h0001_8000);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Count/Compare timer
    mtc0(5'd12, 32'h0000_8001);
    check("status_write", status, 32'h0000_8001);
    mtc0(5'd9, 32'h0000_0010);
    mtc0(5'd11, 32'h0000_0012);
    check("ti_cleared_by_compare", {31'd0, timer_int}, 32'd0);
    mfc0(5'd9, 3'd0, rd);
    check("count_after_1", rd, 32'h0000_0010);
    step();
    mfc0(5'd9, 3'd0, rd);
    check("count_after_2", rd, 32'h0000_0011);
    step();
    step();
    mfc0(5'd9, 3'd0, rd);
    check("count_after_4", rd, 32'h0000_0012);
    check("ti_not_yet", {31'd0, timer_int}, 32'd0);
    step();
    check("ti_set", {31'd0, timer_int}, 32'd1);
    check("int_pending_timer", {31'd0, int_pending}, 32'd1);
    check("cause_ti_ip7", cause, 32'h4000_8000);
    mtc0(5'd11, 32'h0000_0100);
    check("ti_clear", {31'd0, timer_int}, 32'd0);
    check("int_pending_clear", {31'd0, int_pending}, 32'd0);

    // Exception in a delay slot, then a nested one
    raise(32'hBFC0_0104, 1'b1, 5'd5, 32'h1234_5671);
    check("exc_epc", epc, 32'hBFC0_0100);
    check("exc_bd", {31'd0, cause[31]}, 32'd1);
    check("exc_code", {27'd0, cause[6:2]}, 32'd5);
    check("exc_exl", status, 32'h0000_8003);
    mfc0(5'd8, 3'd0, rd);
    check("exc_badvaddr", rd, 32'h1234_5671);
    raise(32'h8000_0000, 1'b0, 5'd8, 32'hDEAD_BEEF);
    check("nested_epc", epc, 32'hBFC0_0100);
    check("nested_bd", {31'd0, cause[31]}, 32'd1);
    check("nested_code", {27'd0, cause[6:2]}, 32'd8);
    mfc0(5'd8, 3'd0, rd);
    check("nested_badvaddr", rd, 32'h1234_5671);

    // Same-cycle priority
    eret = 1'b1;
    write_en = 1'b1; write_addr = 5'd12; write_sel = 3'd0; write_data = 32'h0;
    raise(32'h0000_0040, 1'b0, 5'd0, 32'h0);
    check("prio_status", status, 32'h0000_8003);
    check("prio_epc", epc, 32'hBFC0_0100);
    step();
    check("eret_status", status, 32'h0000_8001);
    write_data = 32'h0000_1234; write_addr = 5'd14;
    step();
    eret = 1'b0;
    write_en = 1'b0;
    check("eret_epc_write", epc, 32'h0000_1234);
    check("eret_status_kept", status, 32'h0000_8001);

    // Bypass and masking
    write_en = 1'b1; write_addr = 5'd12; write_sel = 3'd0; write_data = 32'hFFFF_FFFF;
    mfc0(5'd12, 3'd0, rd);
    check("bypass_status", rd, 32'h1040_FF03);
    step();
    write_en = 1'b0;
    check("status_masked", status, 32'h1040_FF03);
    mtc0(5'd12, 32'h0);
    int_in = 6'b000001;
    step();
    mfc0(5'd13, 3'd0, rd);
    check("cause_ip2", rd & 32'h0000_FF00, 32'h0000_0400);
    mtc0(5'd13, 32'h0000_0300);
    check("cause_ip_sw", cause & 32'h0000_FF00, 32'h0000_0700);
    write_en = 1'b1; write_addr = 5'd15; write_data = 32'h0;
    mfc0(5'd15, 3'd0, rd);
    check("prid_bypass_ro", rd, 32'h0001_8000);
    step();
    write_en = 1'b0;
    mfc0(5'd15, 3'd0, rd);
    check("prid_ro", rd, 32'h0001_8000);
    mfc0(5'd12, 3'd1, rd);
    check("sel1_zero", rd, 32'h0);
    int_in = 6'd0;

    // Count wrap and Compare=0
    mtc0(5'd11, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    mfc0(5'd9, 3'd0, rd);
    check("wrap_load", rd, 32'hFFFF_FFFF);
    step();
    step();
    mfc0(5'd9, 3'd0, rd);
    check("wrap_zero", rd, 32'h0);
    check("wrap_ti_not_yet", {31'd0, timer_int}, 32'd0);
    step();
    check("wrap_ti", {31'd0, timer_int}, 32'd1);

    // Mid-run reset
    step(); step(); step(); step();
    mfc0(5'd9, 3'd0, rd);
    check("count_advanced", rd, 32'h0000_0002);
    rst = 1'b1;
    #1;
    mfc0(5'd9, 3'd0, rd);
    check("rst_count", rd, 32'h0);
    check("rst_status", status, 32'h0040_0000);
    check("rst_cause", cause, 32'h0);
    check("rst_int_pending", {31'd0, int_pending}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
